// File: rtl/i2c_controller_core_if.sv
// Host/pad bundle for the single-byte I2C master.
// The core takes the master modport; the host side takes slave.
interface i2c_controller_core_if;
    logic       enable;
    logic [6:0] slave_address;
    logic [7:0] data_in;
    logic       rw;
    logic       repeated_start_cond;
    logic       sda_in;
    logic       scl_in;
    logic       sda_out;
    logic       scl_out;

    modport master (
        input  enable, slave_address, data_in, rw,
        input  repeated_start_cond, sda_in, scl_in,
        output sda_out, scl_out
    );

    modport slave (
        output enable, slave_address, data_in, rw,
        output repeated_start_cond, sda_in, scl_in,
        input  sda_out, scl_out
    );
endinterface

// File: rtl/i2c_controller_core.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, STOP/Sr.
// Define I2C_CLK_STRETCH_EN to freeze timing while a slave holds SCL low.
module i2c_controller_core #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    i2c_controller_core_if.master bus
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(DIV / 2);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WR_DATA  = 4'd4,
        WR_ACK   = 4'd5,
        RD_DATA  = 4'd6,
        RD_ACK   = 4'd7,
        STOP     = 4'd8
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_addr;
    logic [7:0]    shift_data;
    logic [7:0]    rx_data;
    logic          sampled;
    logic          wrap;
    logic          last_bit;
    logic          load;
    logic          freeze;
    logic          end_rs;
    logic          sda_d;
    logic          scl_d;

    assign wrap     = (phase == LAST);
    assign last_bit = wrap && (bit_cnt == 3'd7);
    assign end_rs   = bus.repeated_start_cond && bus.enable;
    // Inputs are (re)latched on every entry into START, including Sr.
    assign load     = (next_state == START) && (state != START);

`ifdef I2C_CLK_STRETCH_EN
    assign freeze = scl_d && !bus.scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = bus.scl_in;
    assign freeze        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            bit_cnt    <= 3'd0;
            shift_addr <= 8'h00;
            shift_data <= 8'h00;
            rx_data    <= 8'h00;
            sampled    <= 1'b1;
        end else if (!freeze) begin
            state <= next_state;
            if (state == IDLE || wrap)
                phase <= '0;
            else
                phase <= phase + 1'b1;
            if (next_state != state)
                bit_cnt <= 3'd0;
            else if (wrap)
                bit_cnt <= bit_cnt + 3'd1;
            if (load) begin
                shift_addr <= {bus.slave_address, bus.rw};
                shift_data <= bus.data_in;
            end
            if (phase == HALF)
                sampled <= bus.sda_in;
            if (state == RD_DATA && phase == HALF)
                rx_data <= {rx_data[6:0], bus.sda_in};
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (bus.enable) next_state = START;
            START:    if (wrap) next_state = ADDR;
            ADDR:     if (last_bit) next_state = ADDR_ACK;
            ADDR_ACK: begin
                if (wrap) begin
                    if (sampled)
                        next_state = STOP;
                    else if (shift_addr[0])
                        next_state = RD_DATA;
                    else
                        next_state = WR_DATA;
                end
            end
            WR_DATA:  if (last_bit) next_state = WR_ACK;
            RD_DATA:  if (last_bit) next_state = RD_ACK;
            WR_ACK, RD_ACK: begin
                if (wrap) begin
                    if (end_rs)
                        next_state = START;
                    else
                        next_state = STOP;
                end
            end
            STOP:     if (wrap) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so they hold for a whole cycle.
    always_comb begin
        sda_d = 1'b1;
        scl_d = 1'b1;
        unique case (state)
            START: sda_d = (phase < HALF);
            ADDR: begin
                scl_d = (phase >= HALF);
                sda_d = shift_addr[~bit_cnt];
            end
            WR_DATA: begin
                scl_d = (phase >= HALF);
                sda_d = shift_data[~bit_cnt];
            end
            ADDR_ACK, WR_ACK, RD_DATA, RD_ACK: scl_d = (phase >= HALF);
            STOP: begin
                scl_d = (phase != '0);
                sda_d = (phase >= HALF);
            end
            default: begin
                sda_d = 1'b1;
                scl_d = 1'b1;
            end
        endcase
    end

    assign bus.sda_out = sda_d;
    assign bus.scl_out = scl_d;
endmodule

// File: tb/tb_i2c_controller_core.sv
// Directed bench for i2c_controller_core (DIV=4, no clock stretching).
// Captures SDA/SCL per cycle and checks waveforms against hand values.
module tb_i2c_controller_core;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic sda_cap  [0:159];
    logic scl_cap  [0:159];
    logic busy_cap [0:159];

    i2c_controller_core_if bus ();

    i2c_controller_core #(.DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.scl_in = bus.scl_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pat(input int p, input logic use_scl);
        logic [3:0] r;
        for (int ph = 0; ph < 4; ph++)
            r[3-ph] = use_scl ? scl_cap[p*4+ph] : sda_cap[p*4+ph];
        return r;
    endfunction

    function automatic logic [7:0] byte_at(input int p0);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[7-i] = sda_cap[(p0+i)*4+2];
        return r;
    endfunction

    function automatic int stab_errs(input int p0, input int p1);
        int n;
        n = 0;
        for (int p = p0; p <= p1; p++)
            for (int ph = 1; ph < 4; ph++)
                if (sda_cap[p*4+ph] !== sda_cap[p*4]) n++;
        return n;
    endfunction

    function automatic int scl_errs(input int p0, input int p1);
        int n;
        n = 0;
        for (int p = p0; p <= p1; p++)
            for (int ph = 0; ph < 4; ph++)
                if (scl_cap[p*4+ph] !== (ph >= 2)) n++;
        return n;
    endfunction

    // Slave side: ACK slots, read data bits, otherwise released.
    function automatic logic slave_bit(input int k, input logic r,
                                       input logic ack_a, input logic ack_d,
                                       input logic [7:0] rd, input logic rs);
        int p;
        p = k / 4;
        if (rs && p >= 19) p = p - 19;
        if (p == 9) return ack_a;
        if (p == 18) return ack_d;
        if (r && p >= 10 && p <= 17) return rd[17-p];
        return 1'b1;
    endfunction

    task automatic xfer(input logic [6:0] a, input logic r, input logic [7:0] d,
                        input logic ack_a, input logic ack_d,
                        input logic [7:0] rd, input logic rs,
                        input int hold, input int ncyc);
        @(negedge clk);
        bus.slave_address       = a;
        bus.rw                  = r;
        bus.data_in             = d;
        bus.repeated_start_cond = rs;
        bus.enable              = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            sda_cap[k]  = bus.sda_out;
            scl_cap[k]  = bus.scl_out;
            busy_cap[k] = (dut.state != 0);
            if (k == hold) begin
                bus.enable              = 1'b0;
                bus.repeated_start_cond = 1'b0;
            end
            bus.sda_in = slave_bit(k, r, ack_a, ack_d, rd, rs);
        end
    endtask

    task automatic chk_idle(input string tag, input int ncyc);
        int n;
        n = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (bus.sda_out !== 1'b1 || bus.scl_out !== 1'b1 || dut.state != 0)
                n++;
        end
        chk(tag, n, 0);
    endtask

    initial begin
        total                   = 0;
        bad                     = 0;
        rst                     = 1'b1;
        bus.enable              = 1'b0;
        bus.slave_address       = 7'h00;
        bus.data_in             = 8'h00;
        bus.rw                  = 1'b0;
        bus.repeated_start_cond = 1'b0;
        bus.sda_in              = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sda", bus.sda_out, 1);
        chk("rst_scl", bus.scl_out, 1);
        chk("rst_rx", dut.rx_data, 8'h00);
        chk("rst_state", dut.state, 0);
        rst = 1'b0;
        chk_idle("rst_idle", 4);

        // Write 0x6B / 0xAA, both ACKed
        xfer(7'h6B, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 0, 80);
        chk("wr_start_sda", pat(0, 0), 4'b1100);
        chk("wr_start_scl", pat(0, 1), 4'b1111);
        chk("wr_addr", byte_at(1), 8'hD6);
        chk("wr_ack1", pat(9, 0), 4'b1111);
        chk("wr_data", byte_at(10), 8'hAA);
        chk("wr_ack2", pat(18, 0), 4'b1111);
        chk("wr_stop_sda", pat(19, 0), 4'b0011);
        chk("wr_stop_scl", pat(19, 1), 4'b0111);
        chk("wr_scl", scl_errs(1, 18), 0);
        chk("wr_stable", stab_errs(1, 18), 0);
        chk("wr_busy79", busy_cap[79], 1);
        chk_idle("wr_idle80", 6);

        // Address NACK: STOP straight after the ACK slot
        xfer(7'h6B, 1'b0, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b0, 0, 44);
        chk("nack_addr", byte_at(1), 8'hD6);
        chk("nack_slot", pat(9, 0), 4'b1111);
        chk("nack_stop_sda", pat(10, 0), 4'b0011);
        chk("nack_stop_scl", pat(10, 1), 4'b0111);
        chk("nack_busy43", busy_cap[43], 1);
        chk_idle("nack_idle", 40);

        // Read: slave returns 0x3C, master NACKs
        xfer(7'h6B, 1'b1, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 0, 80);
        chk("rd_addr", byte_at(1), 8'hD7);
        chk("rd_release", byte_at(10), 8'hFF);
        chk("rd_nack", pat(18, 0), 4'b1111);
        chk("rd_stop_sda", pat(19, 0), 4'b0011);
        chk("rd_rx", dut.rx_data, 8'h3C);
        chk_idle("rd_idle", 4);

        // Repeated START with enable held
        xfer(7'h6B, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b1, 100, 156);
        chk("rs_rise", {sda_cap[71], sda_cap[72], scl_cap[72]}, 3'b010);
        chk("rs_start_scl", pat(19, 1), 4'b1111);
        chk("rs_start_sda", pat(19, 0), 4'b1100);
        chk("rs_addr2", byte_at(20), 8'hD6);
        chk("rs_data2", byte_at(29), 8'hAA);
        chk("rs_stop_sda", pat(38, 0), 4'b0011);
        chk("rs_busy155", busy_cap[155], 1);
        chk_idle("rs_idle", 4);

        // Reset in the middle of ADDR
        bus.slave_address = 7'h6B;
        bus.rw            = 1'b0;
        bus.data_in       = 8'hAA;
        bus.enable        = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (10) @(negedge clk);
        chk("mr_pre", dut.state, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_sda", bus.sda_out, 1);
        chk("mr_scl", bus.scl_out, 1);
        chk("mr_state", dut.state, 0);
        rst = 1'b0;
        chk_idle("mr_idle", 4);
        xfer(7'h12, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 0, 80);
        chk("mr_addr", byte_at(1), 8'h24);
        chk("mr_data", byte_at(10), 8'h5A);
        chk("mr_stop", pat(19, 0), 4'b0011);
        chk_idle("mr_idle80", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
